relu_vec: RTL and testbench

RELU_VEC -- requirements
Module: relu_vec

---
 rtl/relu_vec.sv | 183 ++++++++++++++++++
 tb/tb_relu_vec.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_vec.sv
// relu_vec: two-stage pipelined vector activation unit over LANES float32 lanes.
//   Modes: 00 bypass, 01 ReLU, 10 leaky ReLU (slope 2^-LEAK_SHIFT), 11 clipped ReLU.
//   S1 captures the beat plus a per-lane class (NaN, Inf, zero/denormal, sign);
//   S2 holds the mapped lanes. stat_cnt counts clipped or flushed lanes (saturating).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   0 forces all lanes of the beat to +0 and suppresses counting
//   mode                 activation select, sampled with each accepted beat
//   in_valid/in_ready    input handshake; in_data lane i at [32i+31:32i]
//   out_valid/out_ready  output handshake; out_data has the same packing
//   stat_cnt, stat_clr   statistics counter and its synchronous clear (clear wins)
module relu_vec #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter logic [31:0] CLIP_VAL   = 32'h40C00000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [CNT_W-1:0]      stat_cnt,
  input  logic                  stat_clr
);

  localparam int unsigned W    = 32 * LANES;
  localparam int unsigned SumW = CNT_W + 5;
  localparam logic [7:0]  LeakExp = 8'(LEAK_SHIFT);
  localparam logic [31:0] QNaN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    ModeBypass = 2'b00,
    ModeRelu   = 2'b01,
    ModeLeaky  = 2'b10,
    ModeClip   = 2'b11
  } mode_e;

  logic             s1_valid_q, s1_en_q;
  mode_e            s1_mode_q;
  logic [W-1:0]     s1_data_q;
  logic [LANES-1:0] s1_nan_q, s1_inf_q, s1_zero_q, s1_sign_q;
  logic [LANES-1:0] nan_d, inf_d, zero_d, sign_d;

  logic             s2_valid_q;
  logic [W-1:0]     s2_data_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]  cnt_sum;

  logic             s1_load, s1_adv;
  logic [W-1:0]     map_data;
  logic [4:0]       hit_cnt;
  logic [31:0]      lane, res;
  logic             hit;

  // S2 is the last stage, so it drains whenever out_ready is high.
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign s1_load  = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign stat_cnt  = cnt_q;

  always_comb begin
    nan_d  = '0;
    inf_d  = '0;
    zero_d = '0;
    sign_d = '0;
    for (int i = 0; i < LANES; i++) begin
      nan_d[i]  = (in_data[32*i+23 +: 8] == 8'hFF) && (in_data[32*i +: 23] != '0);
      inf_d[i]  = (in_data[32*i+23 +: 8] == 8'hFF) && (in_data[32*i +: 23] == '0);
      zero_d[i] = (in_data[32*i+23 +: 8] == 8'h00);
      sign_d[i] = in_data[32*i+31];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_mode_q  <= ModeBypass;
      s1_data_q  <= '0;
      s1_nan_q   <= '0;
      s1_inf_q   <= '0;
      s1_zero_q  <= '0;
      s1_sign_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_en_q    <= en;
        s1_mode_q  <= mode_e'(mode);
        s1_data_q  <= in_data;
        s1_nan_q   <= nan_d;
        s1_inf_q   <= inf_d;
        s1_zero_q  <= zero_d;
        s1_sign_q  <= sign_d;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Per-lane mapping; hit marks a lane that was clipped or flushed to zero.
  always_comb begin
    map_data = '0;
    hit_cnt  = '0;
    lane     = '0;
    res      = '0;
    hit      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane = s1_data_q[32*i +: 32];
      res  = lane;
      hit  = 1'b0;
      if (!s1_en_q) begin
        res = '0;
      end else if (s1_mode_q != ModeBypass && s1_nan_q[i]) begin
        res = QNaN;
      end else begin
        case (s1_mode_q)
          ModeRelu: begin
            if (s1_sign_q[i]) res = '0;
          end
          ModeLeaky: begin
            // -Inf passes through unchanged; other negatives scale by exponent.
            if (s1_sign_q[i] && !s1_inf_q[i]) begin
              if (lane[30:23] <= LeakExp) begin
                res = '0;
                hit = !(s1_zero_q[i] && lane[22:0] == '0);
              end else begin
                res = {1'b1, lane[30:23] - LeakExp, lane[22:0]};
              end
            end
          end
          ModeClip: begin
            if (s1_sign_q[i]) begin
              res = '0;
            end else if (lane[30:0] > CLIP_VAL[30:0]) begin
              res = CLIP_VAL;
              hit = 1'b1;
            end
          end
          default: ;
        endcase
      end
      map_data[32*i +: 32] = res;
      hit_cnt = hit_cnt + 5'(hit);
    end
  end

  always_comb begin
    cnt_sum = {5'b0, cnt_q} + SumW'(hit_cnt);
    cnt_d   = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (s1_adv) begin
      cnt_d = (cnt_sum[SumW-1:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_data_q  <= map_data;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_vec.sv
// tb_relu_vec: directed self-checking bench for relu_vec (LANES=4, defaults elsewhere).
module tb_relu_vec;
  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_data;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       out_data;
  logic [CNT_W-1:0]   stat_cnt;
  logic               stat_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  relu_vec #(
    .LANES      (LANES),
    .LEAK_SHIFT (3),
    .CLIP_VAL   (32'h40C00000),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stat_cnt  (stat_cnt),
    .stat_clr  (stat_clr)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
  endtask

  // Single beat on an idle pipe; checks the fixed two-cycle latency and the data.
  task automatic run_beat(input string tag, input logic [1:0] m, input logic e,
                          input logic [127:0] d, input logic [127:0] exp_d);
    mode      = m;
    en        = e;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, 128'(out_valid), 128'(0));
    cyc();
    check_eq({tag, "_vld"}, 128'(out_valid), 128'(1));
    check_eq({tag, "_dat"}, out_data, exp_d);
  endtask

  logic [127:0] str_beats[8];
  logic [15:0]  pat;
  logic [127:0] prev_data;
  logic         prev_stall;
  int           sent, rcv, occ;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    mode      = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;

    #12;
    check_eq("rst_vld", 128'(out_valid), 128'(0));
    check_eq("rst_dat", out_data, 128'(0));
    check_eq("rst_cnt", 128'(stat_cnt), 128'(0));
    #10 rst_n = 1'b1;
    cyc();
    check_eq("rst_rdy", 128'(in_ready), 128'(1));

    run_beat("relu_a", 2'b01, 1'b1,
             pack4(32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7FC00001),
             pack4(32'h3F800000, 32'h00000000, 32'h00000000, 32'h7FC00000));
    check_eq("relu_a_cnt", 128'(stat_cnt), 128'(0));

    run_beat("leaky_a", 2'b10, 1'b1,
             pack4(32'hC0000000, 32'h80800000, 32'hFF800000, 32'h40000000),
             pack4(32'hBE800000, 32'h00000000, 32'hFF800000, 32'h40000000));
    check_eq("leaky_a_cnt", 128'(stat_cnt), 128'(1));

    run_beat("clip_a", 2'b11, 1'b1,
             pack4(32'h40E00000, 32'h7F800000, 32'h40A00000, 32'hC1200000),
             pack4(32'h40C00000, 32'h40C00000, 32'h40A00000, 32'h00000000));
    check_eq("clip_a_cnt", 128'(stat_cnt), 128'(3));

    run_beat("bypass", 2'b00, 1'b1,
             pack4(32'h7FC00001, 32'hFF812345, 32'h80000001, 32'h12345678),
             pack4(32'h7FC00001, 32'hFF812345, 32'h80000001, 32'h12345678));
    check_eq("bypass_cnt", 128'(stat_cnt), 128'(3));

    // exp==3 flushes (counted), exp==4 scales, neg denormal flushes (counted), -0 not counted
    run_beat("leaky_b", 2'b10, 1'b1,
             pack4(32'h81800000, 32'h82000000, 32'h80000001, 32'h80000000),
             pack4(32'h00000000, 32'h80800000, 32'h00000000, 32'h00000000));
    check_eq("leaky_b_cnt", 128'(stat_cnt), 128'(5));

    run_beat("clip_b", 2'b11, 1'b1,
             pack4(32'h40C00000, 32'h40C00001, 32'h7FC00000, 32'h00000000),
             pack4(32'h40C00000, 32'h40C00000, 32'h7FC00000, 32'h00000000));
    check_eq("clip_b_cnt", 128'(stat_cnt), 128'(6));

    run_beat("relu_b", 2'b01, 1'b1,
             pack4(32'hFF800000, 32'h7F800000, 32'h00000001, 32'h80000001),
             pack4(32'h00000000, 32'h7F800000, 32'h00000001, 32'h00000000));

    run_beat("en0_clip", 2'b11, 1'b0,
             pack4(32'h7F800000, 32'h40E00000, 32'h3F800000, 32'hBF800000),
             128'(0));
    check_eq("en0_clip_cnt", 128'(stat_cnt), 128'(6));

    run_beat("leaky_nan", 2'b10, 1'b1,
             pack4(32'hFFC00000, 32'h7FC12345, 32'h3F800000, 32'hC0800000),
             pack4(32'h7FC00000, 32'h7FC00000, 32'h3F800000, 32'hBF000000));
    check_eq("leaky_nan_cnt", 128'(stat_cnt), 128'(6));

    // Streaming with a fixed pseudo-random out_ready pattern.
    drain();
    for (int k = 0; k < 8; k++) begin
      str_beats[k] = pack4(32'(k + 1), 32'h3F800000 + 32'(k), 32'hC0000000 + 32'(k),
                           32'h7FC00000 + 32'(k));
    end
    pat        = 16'b1011_0010_0110_1001;
    sent       = 0;
    rcv        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    mode       = 2'b00;
    en         = 1'b1;
    for (int c = 0; c < 200 && rcv < 8; c++) begin
      out_ready = pat[c % 16];
      in_valid  = (sent < 8);
      if (sent < 8) in_data = str_beats[sent];
      #1;
      if (prev_stall) begin
        check_eq("str_hold_vld", 128'(out_valid), 128'(1));
        check_eq("str_hold_dat", out_data, prev_data);
      end
      occ = sent - rcv;
      check_eq("str_rdy", 128'(in_ready), 128'(!(occ == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        check_eq("str_dat", out_data, str_beats[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      cyc();
    end
    in_valid = 1'b0;
    check_eq("str_count", 128'(rcv), 128'(8));

    // Saturation: clear, fill to 2^16-2, add 3, then clear on an incrementing cycle.
    drain();
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    check_eq("clr", 128'(stat_cnt), 128'(0));
    mode     = 2'b11;
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = {4{32'h7F000000}};
    for (int n = 0; n < 16383; n++) cyc();
    in_data = pack4(32'h7F000000, 32'h7F000000, 32'h00000000, 32'h00000000);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    check_eq("pre_sat", 128'(stat_cnt), 128'(65534));

    run_beat("sat", 2'b11, 1'b1,
             pack4(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h3F800000),
             pack4(32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h3F800000));
    check_eq("sat_cnt", 128'(stat_cnt), 128'(65535));

    drain();
    in_data  = pack4(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h00000000);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    check_eq("clrwin_vld", 128'(out_valid), 128'(1));
    check_eq("clrwin_cnt", 128'(stat_cnt), 128'(0));

    // Reset with two beats in flight.
    drain();
    out_ready = 1'b0;
    mode      = 2'b11;
    en        = 1'b1;
    in_valid  = 1'b1;
    in_data   = pack4(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h00000000);
    cyc();
    in_data = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    cyc();
    in_valid = 1'b0;
    check_eq("rst2_pre_vld", 128'(out_valid), 128'(1));
    check_eq("rst2_pre_rdy", 128'(in_ready), 128'(0));
    check_eq("rst2_pre_cnt", 128'(stat_cnt), 128'(3));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst2_vld", 128'(out_valid), 128'(0));
    check_eq("rst2_dat", out_data, 128'(0));
    check_eq("rst2_cnt", 128'(stat_cnt), 128'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc();
      check_eq("rst2_stale", 128'(out_valid), 128'(0));
    end

    run_beat("en0_byp", 2'b00, 1'b0,
             pack4(32'h3F800000, 32'hFFFFFFFF, 32'h7FC00001, 32'h12345678),
             128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
